// File: rtl/morph_frame_sched_if.sv
// morph_frame_sched_if: pixel-stream control and window-engine select bundle
interface morph_frame_sched_if #(parameter int CW = 10);
    logic          sof;
    logic          dval;
    logic [2:0]    mode;
    logic          clken;
    logic          flush;
    logic          win_val;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic          border;
    logic [1:0]    op0;
    logic [1:0]    op1;
    logic          eof;
    logic          busy;
    logic          err;
    modport master (output sof, dval, mode,
                    input  clken, flush, win_val, cx, cy, border, op0, op1, eof, busy, err);
    modport slave  (input  sof, dval, mode,
                    output clken, flush, win_val, cx, cy, border, op0, op1, eof, busy, err);
endinterface

// File: rtl/morph_frame_sched.sv
// morph_frame_sched: frame sequencer for the 3x3 morphology line buffer and window stages
module morph_frame_sched #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int CW       = 10,
    parameter int NW       = 17
) (
    input  logic iclk,
    input  logic irst_n,
    morph_frame_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRIME, ACTIVE, FLUSH, DONE} state_t;
    localparam int FW = CW + 1;
    localparam logic [NW-1:0] PRIME_END = NW'(H_ACTIVE);
    localparam logic [NW-1:0] LAST_PIX  = NW'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'(H_ACTIVE);
    localparam logic [CW-1:0] X_LAST    = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(V_ACTIVE - 1);
    state_t st, st_nxt;
    logic [NW-1:0] in_cnt;
    logic [FW-1:0] fl_cnt;
    logic [CW-1:0] px, py;
    logic [1:0] op0_m, op1_m;
    logic acc, fl_feed, emit, x_wrap;
    always_comb begin
        acc     = bus.dval & (bus.sof | st == PRIME | st == ACTIVE);
        // an iSOF during FLUSH restarts the frame, so that cycle shifts pixel data, not padding
        fl_feed = st == FLUSH & ~bus.sof;
        emit    = ~bus.sof & (acc & st == ACTIVE | fl_feed);
        x_wrap  = px == X_LAST;
        op0_m   = (bus.mode == 3'd1 | bus.mode == 3'd3) ? 2'b01 :
                  (bus.mode == 3'd2 | bus.mode == 3'd4) ? 2'b10 : 2'b00;
        op1_m   = bus.mode == 3'd3 ? 2'b10 : bus.mode == 3'd4 ? 2'b01 : 2'b00;
        st_nxt  = st;
        if (bus.sof)
            st_nxt = PRIME;
        else
            case (st)
                PRIME:   st_nxt = (acc & in_cnt == PRIME_END) ? ACTIVE : PRIME;
                ACTIVE:  st_nxt = (acc & in_cnt == LAST_PIX) ? FLUSH : ACTIVE;
                FLUSH:   st_nxt = fl_cnt == FLUSH_END ? DONE : FLUSH;
                DONE:    st_nxt = IDLE;
                default: st_nxt = IDLE;
            endcase
    end
    assign bus.clken = acc | fl_feed;
    assign bus.flush = fl_feed;
    assign bus.busy  = st != IDLE;
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            st          <= IDLE;
            in_cnt      <= '0;
            fl_cnt      <= '0;
            px          <= '0;
            py          <= '0;
            bus.win_val <= 1'b0;
            bus.cx      <= '0;
            bus.cy      <= '0;
            bus.border  <= 1'b0;
            bus.op0     <= 2'b00;
            bus.op1     <= 2'b00;
            bus.eof     <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            st          <= st_nxt;
            bus.win_val <= emit;
            bus.border  <= emit & (px == '0 | x_wrap | py == '0 | py == Y_LAST);
            bus.eof     <= st == DONE & ~bus.sof;
            bus.err     <= bus.sof & st != IDLE | st == FLUSH & bus.dval;
            if (emit) begin
                bus.cx <= px;
                bus.cy <= py;
            end
            if (bus.sof) begin
                bus.op0 <= op0_m;
                bus.op1 <= op1_m;
                in_cnt  <= NW'(acc);
                fl_cnt  <= '0;
                px      <= '0;
                py      <= '0;
            end else begin
                in_cnt <= acc ? in_cnt + 1'b1 : in_cnt;
                fl_cnt <= fl_feed ? fl_cnt + 1'b1 : fl_cnt;
                // raster wrap counters stand in for c mod H / c div H
                px     <= emit ? (x_wrap ? '0 : px + 1'b1) : px;
                py     <= (emit & x_wrap) ? py + 1'b1 : py;
            end
        end
    end
endmodule

// File: tb/tb_morph_frame_sched.sv
// tb_morph_frame_sched: directed frame sequences for morph_frame_sched at 8x4
module tb_morph_frame_sched;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 4;
    localparam int NW = 6;
    logic iclk = 1'b0;
    logic irst_n = 1'b0;
    always #5 iclk = ~iclk;
    morph_frame_sched_if #(.CW(CW)) bus ();
    morph_frame_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW), .NW(NW)) dut (
        .iclk(iclk), .irst_n(irst_n), .bus(bus)
    );
    int n_cmp = 0;
    int n_bad = 0;
    int cnum = 0;
    int wn, feeds, first_feeds, fl_cyc, bad_clk, eofs, errs, eof_cyc, last_win_cyc;
    int wx[64], wy[64], wb[64];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask
    task automatic clear();
        wn = 0; feeds = 0; first_feeds = -1; fl_cyc = 0; bad_clk = 0;
        eofs = 0; errs = 0; eof_cyc = -1; last_win_cyc = -1;
    endtask
    task automatic cyc(input logic s, input logic d, input logic [2:0] m);
        @(negedge iclk);
        bus.sof = s; bus.dval = d; bus.mode = m;
        #1;
        if (bus.clken) feeds++;
        if (bus.flush) fl_cyc++;
        if (bus.clken && !bus.flush && !d) bad_clk++;
        @(posedge iclk);
        #1;
        cnum++;
        if (bus.win_val) begin
            if (wn == 0) first_feeds = feeds;
            if (wn < 64) begin
                wx[wn] = int'(bus.cx); wy[wn] = int'(bus.cy); wb[wn] = int'(bus.border);
            end
            wn++;
            last_win_cyc = cnum;
        end
        if (bus.eof) begin eofs++; eof_cyc = cnum; end
        if (bus.err) errs++;
    endtask
    task automatic frame(input logic [2:0] m, input bit bub, input int inj);
        cyc(1'b1, 1'b1, m);
        for (int i = 1; i < H * V; i++) begin
            if (bub) cyc(1'b0, 1'b0, m);
            cyc(1'b0, 1'b1, m);
        end
        for (int k = 0; k < 14; k++) cyc(1'b0, k == inj, m);
    endtask
    task automatic chk_raster(input string tag, input int off);
        int bad = 0;
        for (int i = 0; i < H * V; i++)
            if (wx[off + i] != i % H || wy[off + i] != i / H) bad++;
        chk(tag, bad, 0);
    endtask
    task automatic chk_border();
        int bad = 0;
        int ones = 0;
        for (int i = 0; i < H * V; i++) begin
            if (wb[i] != int'(wx[i] == 0 || wx[i] == H - 1 || wy[i] == 0 || wy[i] == V - 1)) bad++;
            ones += wb[i];
        end
        chk("border_map", bad, 0);
        chk("border_ones", ones, 20);
    endtask
    function automatic logic [31:0] outs();
        return 32'({bus.clken, bus.flush, bus.win_val, bus.cx, bus.cy, bus.border,
                    bus.op0, bus.op1, bus.eof, bus.busy, bus.err});
    endfunction
    initial begin
        bus.sof = 1'b0; bus.dval = 1'b0; bus.mode = 3'd0;
        clear();
        repeat (2) @(posedge iclk);
        #1;
        chk("reset_outs", outs(), 0);
        @(negedge iclk);
        irst_n = 1'b1;
        // open frame, contiguous pixels
        clear();
        frame(3'd3, 1'b0, -1);
        chk("t1_first_win_feeds", first_feeds, 10);
        chk("t1_win_count", wn, 32);
        chk_raster("t1_raster", 0);
        chk("t1_flush_cycles", fl_cyc, 9);
        chk("t1_feeds", feeds, 41);
        chk("t1_eof_count", eofs, 1);
        chk("t1_eof_after_last", eof_cyc, last_win_cyc + 1);
        chk("t1_last_x", wx[31], 7);
        chk("t1_last_y", wy[31], 3);
        chk("t1_op0", bus.op0, 2'b01);
        chk("t1_op1", bus.op1, 2'b10);
        chk("t1_err", errs, 0);
        chk("t1_busy_after", bus.busy, 0);
        chk("t3_wrap_x", wx[8], 0);
        chk("t3_wrap_y", wy[8], 1);
        chk_border();
        // 1-on/1-off pixel bubbles
        clear();
        frame(3'd3, 1'b1, -1);
        chk("t2_win_count", wn, 32);
        chk_raster("t2_raster", 0);
        chk("t2_clken_no_dval", bad_clk, 0);
        chk("t2_feeds", feeds, 41);
        chk("t2_flush_cycles", fl_cyc, 9);
        chk("t2_eof_count", eofs, 1);
        // abort at pixel 15, then a full dilate frame
        clear();
        cyc(1'b1, 1'b1, 3'd1);
        for (int i = 1; i < 15; i++) cyc(1'b0, 1'b1, 3'd1);
        chk("t4_pre_abort_wins", wn, 6);
        frame(3'd2, 1'b0, -1);
        chk("t4_err", errs, 1);
        chk("t4_eof_count", eofs, 1);
        chk("t4_win_count", wn, 38);
        chk("t4_pre_abort_x", wx[5], 5);
        chk_raster("t4_raster", 6);
        chk("t4_op0", bus.op0, 2'b10);
        chk("t4_op1", bus.op1, 2'b00);
        // iDVAL during FLUSH
        clear();
        frame(3'd4, 1'b0, 3);
        chk("t5_err", errs, 1);
        chk("t5_flush_cycles", fl_cyc, 9);
        chk("t5_win_count", wn, 32);
        chk_raster("t5_raster", 0);
        chk("t5_eof_count", eofs, 1);
        chk("t5_op0", bus.op0, 2'b10);
        chk("t5_op1", bus.op1, 2'b01);
        // async reset mid-ACTIVE
        clear();
        cyc(1'b1, 1'b1, 3'd3);
        for (int i = 1; i < 20; i++) cyc(1'b0, 1'b1, 3'd3);
        chk("t6_busy_before", bus.busy, 1);
        @(negedge iclk);
        #2 irst_n = 1'b0;
        #1;
        chk("t6_reset_outs", outs(), 0);
        @(negedge iclk);
        irst_n = 1'b1;
        clear();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 3'd3);
        chk("t6_no_sof_feeds", feeds, 0);
        chk("t6_no_sof_busy", bus.busy, 0);
        chk("t6_no_sof_wins", wn, 0);
        clear();
        frame(3'd7, 1'b0, -1);
        chk("t6_win_count", wn, 32);
        chk("t6_eof_count", eofs, 1);
        chk("t6_op0", bus.op0, 2'b00);
        chk("t6_op1", bus.op1, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
